// File: rtl/divisor_pkg.sv
// Shared definitions for the synchronous tick controller: FSM encoding,
// reset-time periods and the minimum legal programmed periods.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } estado_t;

  // Defaults reproduce the old /2^5 fast tap and the 2^24-cycle slow tap.
  localparam int unsigned FAST_DEF = 32;
  localparam int unsigned SLOW_DEF = 524288;

  localparam int unsigned FAST_MIN = 2;
  localparam int unsigned SLOW_MIN = 1;

endpackage

// File: rtl/contador_modulo.sv
// Modulo-N counter: advances while enabled, wraps at per-1 and emits a
// registered one-cycle terminal pulse; hit is the combinational wrap condition.
module contador_modulo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] per,
  output logic         hit,
  output logic         term
);

  logic [W-1:0] cnt;
  logic [W-1:0] ultimo;

  assign ultimo = per - W'(1);
  assign hit    = en & (cnt == ultimo);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      term <= 1'b0;
    end else if (hit) begin
      cnt  <= '0;
      term <= 1'b1;
    end else begin
      term <= 1'b0;
      if (en) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/controlador_de_ticks.sv
// Single-clock fast/slow tick generator with start/stop sequencing and a
// valid/ready config port whose updates take effect on slow-period boundaries.
module controlador_de_ticks
  import divisor_pkg::*;
#(
  parameter int          CNT_W    = 24,
  parameter int          SLOW_W   = 20,
  parameter int unsigned FAST_DEF = divisor_pkg::FAST_DEF,
  parameter int unsigned SLOW_DEF = divisor_pkg::SLOW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_fast,
  input  logic [SLOW_W-1:0] cfg_slow,
  output logic              cfg_err,
  output logic              running,
  output logic              tick_fast,
  output logic              tick_slow,
  output logic              sq_fast,
  output logic              sq_slow
);

  estado_t estado, estado_nx;

  logic [CNT_W-1:0]  fast_per, sh_fast;
  logic [SLOW_W-1:0] slow_per, sh_slow;
  logic              xfer, legal, carga;
  logic              fast_hit, slow_hit;
  logic              cuenta_en, cuenta_clr;

  assign xfer  = cfg_valid & cfg_ready;
  assign legal = (cfg_fast >= CNT_W'(FAST_MIN)) && (cfg_slow >= SLOW_W'(SLOW_MIN));
  assign carga = xfer & legal;

  // Stopping (or sitting idle) clears both counters so a restart begins at 0.
  assign cuenta_en  = (estado != IDLE);
  assign cuenta_clr = (estado == IDLE) | stop;

  contador_modulo #(.W(CNT_W)) u_fast (
    .clk  (clk),
    .rst  (rst),
    .en   (cuenta_en),
    .clr  (cuenta_clr),
    .per  (fast_per),
    .hit  (fast_hit),
    .term (tick_fast)
  );

  contador_modulo #(.W(SLOW_W)) u_slow (
    .clk  (clk),
    .rst  (rst),
    .en   (fast_hit),
    .clr  (cuenta_clr),
    .per  (slow_per),
    .hit  (slow_hit),
    .term (tick_slow)
  );

  always_ff @(posedge clk) begin
    if (rst) estado <= IDLE;
    else     estado <= estado_nx;
  end

  always_comb begin
    estado_nx = estado;
    case (estado)
      IDLE:    if (start && !stop) estado_nx = RUN;
      RUN:     if (stop) estado_nx = IDLE;
               else if (carga) estado_nx = PEND;
      PEND:    if (stop) estado_nx = IDLE;
               else if (slow_hit) estado_nx = RUN;
      default: estado_nx = IDLE;
    endcase
  end

  always_comb begin
    running   = (estado != IDLE);
    cfg_ready = (estado != PEND);
  end

  // Active periods only change while the counters are at 0: in IDLE, on stop,
  // or at the slow-terminal edge where both counters wrap together.
  always_ff @(posedge clk) begin
    if (rst) begin
      fast_per <= CNT_W'(FAST_DEF);
      slow_per <= SLOW_W'(SLOW_DEF);
      sh_fast  <= '0;
      sh_slow  <= '0;
    end else begin
      case (estado)
        IDLE: if (carga) begin
          fast_per <= cfg_fast;
          slow_per <= cfg_slow;
        end
        RUN: if (carga) begin
          if (stop) begin
            fast_per <= cfg_fast;
            slow_per <= cfg_slow;
          end else begin
            sh_fast <= cfg_fast;
            sh_slow <= cfg_slow;
          end
        end
        PEND: if (stop || slow_hit) begin
          fast_per <= sh_fast;
          slow_per <= sh_slow;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= xfer & ~legal;
  end

  always_ff @(posedge clk) begin
    if (rst || cuenta_clr) begin
      sq_fast <= 1'b0;
      sq_slow <= 1'b0;
    end else begin
      if (fast_hit) sq_fast <= ~sq_fast;
      if (slow_hit) sq_slow <= ~sq_slow;
    end
  end

endmodule

// File: tb/tb_controlador_de_ticks.sv
// Scoreboard bench for controlador_de_ticks: an elapsed-time reference model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_controlador_de_ticks;

  localparam int CNT_W  = 24;
  localparam int SLOW_W = 20;

  logic              clk = 1'b0;
  logic              rst, start, stop, cfg_valid;
  logic [CNT_W-1:0]  cfg_fast;
  logic [SLOW_W-1:0] cfg_slow;
  logic              cfg_ready, cfg_err, running;
  logic              tick_fast, tick_slow, sq_fast, sq_slow;

  always #5 clk = ~clk;

  controlador_de_ticks #(.CNT_W(CNT_W), .SLOW_W(SLOW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_fast  (cfg_fast),
    .cfg_slow  (cfg_slow),
    .cfg_err   (cfg_err),
    .running   (running),
    .tick_fast (tick_fast),
    .tick_slow (tick_slow),
    .sq_fast   (sq_fast),
    .sq_slow   (sq_slow)
  );

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Model: elapsed cycles since the last (re)start; ticks fall where the
  // elapsed count is a multiple of the fast period / of the whole slow period.
  bit    m_run, m_pend, m_tf, m_ts, m_sqf, m_sqs, m_err;
  longint m_f = 32, m_s = 524288, m_shf = 0, m_shs = 0, m_e = 0;

  task automatic model_step(input bit r, input bit st, input bit sp, input bit v,
                            input longint cf, input longint cs);
    bit xfer, legal;
    longint e1;
    if (r) begin
      m_run = 0; m_pend = 0; m_f = 32; m_s = 524288; m_shf = 0; m_shs = 0;
      m_e = 0; m_tf = 0; m_ts = 0; m_sqf = 0; m_sqs = 0; m_err = 0;
      return;
    end
    xfer  = v && !m_pend;
    legal = (cf >= 2) && (cs >= 1);
    m_err = xfer && !legal;
    if (!m_run) begin
      if (xfer && legal) begin m_f = cf; m_s = cs; end
      m_tf = 0; m_ts = 0;
      if (st && !sp) begin m_run = 1; m_e = 0; end
    end else if (sp) begin
      if (m_pend) begin m_f = m_shf; m_s = m_shs; m_pend = 0; end
      else if (xfer && legal) begin m_f = cf; m_s = cs; end
      m_run = 0; m_tf = 0; m_ts = 0; m_sqf = 0; m_sqs = 0; m_e = 0;
    end else begin
      e1   = m_e + 1;
      m_tf = (e1 % m_f) == 0;
      m_ts = (e1 % (m_f * m_s)) == 0;
      if (m_tf) m_sqf = !m_sqf;
      if (m_ts) m_sqs = !m_sqs;
      if (m_ts && m_pend) begin
        m_f = m_shf; m_s = m_shs; m_pend = 0; m_e = 0;
      end else begin
        m_e = e1;
      end
      if (xfer && legal) begin m_shf = cf; m_shs = cs; m_pend = 1; end
    end
  endtask

  function automatic logic [6:0] model_out();
    return {m_run, !m_pend, m_err, m_tf, m_ts, m_sqf, m_sqs};
  endfunction

  task automatic drive(input bit r, input bit st, input bit sp, input bit v,
                       input int cf, input int cs);
    rst = r; start = st; stop = sp; cfg_valid = v;
    cfg_fast = CNT_W'(cf);
    cfg_slow = SLOW_W'(cs);
    model_step(r, st, sp, v, longint'(cf), longint'(cs));
    @(posedge clk);
    exp_q.push_back('{cyc, model_out()});
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask

  exp_t       e_mon;
  logic [6:0] got;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      got   = {running, cfg_ready, cfg_err, tick_fast, tick_slow, sq_fast, sq_slow};
      tests++;
      if (got !== e_mon.v) begin
        fails++;
        $display("FAIL outputs edge=%0d got=%b required=%b (run rdy err tf ts sqf sqs)",
                 e_mon.cyc, got, e_mon.v);
      end
    end
  end

  initial begin
    // Reset, program 4/3 in IDLE together with start.
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 4, 3);
    idle(30);

    // Reconfigure to 2/2 while running; applied on the next slow boundary.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 4, 3);
    idle(4);
    drive(0, 0, 0, 1, 2, 2);
    idle(20);

    // Illegal offers while running.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 4, 3);
    idle(2);
    drive(0, 0, 0, 1, 1, 5);
    idle(6);
    drive(0, 0, 0, 1, 4, 0);
    idle(10);

    // stop and start together, then a fresh start.
    drive(0, 1, 1, 0, 0, 0);
    idle(3);
    drive(0, 1, 0, 0, 0, 0);
    idle(14);

    // stop while a 6/2 config is pending, then start.
    drive(0, 0, 0, 1, 6, 2);
    idle(2);
    drive(0, 0, 0, 1, 3, 3);
    drive(0, 0, 1, 0, 0, 0);
    idle(2);
    drive(0, 1, 0, 0, 0, 0);
    idle(20);

    // Reset mid-period restores the 32-cycle default.
    idle(7);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    idle(70);

    // Randomized traffic with small periods.
    drive(0, 0, 1, 1, 3, 2);
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 249) == 0,
            $urandom_range(0, 14) == 0,
            $urandom_range(0, 59) == 0,
            $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, 4)));
    end
    idle(5);

    repeat (4) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
